// File: rtl/vstu_commit_ctrl.sv
// Commit/scheduling controller for the vector store unit AXI write path.
// Latency: retire pulse (vinsn_done_o / exception_*) one cycle after the final B beat.
// Backpressure: insn_ready_o drops when QueueDepth instructions are tracked;
//   aw_ready_o drops at MaxOutstanding bursts; b_ready_o only while the head owes a B.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   insn_valid_i/insn_id_i   new store instruction from the sequencer; insn_ready_o = queue not full
//   aw_valid_i/aw_last_i     AW burst issued by the address generator; aw_ready_o grants issue
//   b_valid_i/b_resp_i       AXI B beat; b_ready_o accepts it
//   vinsn_done_o             one-hot retire pulse
//   exception_valid_o/_id_o  retired instruction saw a non-OKAY response
//   store_pending_o          at least one instruction tracked
//   outstanding_o            bursts issued and not yet acknowledged
module vstu_commit_ctrl #(
  parameter int NrVInsn        = 8,
  parameter int QueueDepth     = 4,
  parameter int MaxOutstanding = 16,
  localparam int IdW           = $clog2(NrVInsn),
  localparam int CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                insn_valid_i,
  input  logic [IdW-1:0]      insn_id_i,
  output logic                insn_ready_o,
  output logic                aw_ready_o,
  input  logic                aw_valid_i,
  input  logic                aw_last_i,
  input  logic                b_valid_i,
  input  logic [1:0]          b_resp_i,
  output logic                b_ready_o,
  output logic [NrVInsn-1:0]  vinsn_done_o,
  output logic                exception_valid_o,
  output logic [IdW-1:0]      exception_id_o,
  output logic                store_pending_o,
  output logic [CntW-1:0]     outstanding_o
);

  localparam int PtrW = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
  localparam int OccW = $clog2(QueueDepth + 1);

  // Per-entry tracking state
  logic [IdW-1:0]     r_id     [QueueDepth];
  logic [CntW-1:0]    r_bcnt   [QueueDepth];
  logic               r_closed [QueueDepth];
  logic               r_err    [QueueDepth];

  logic [PtrW-1:0]    r_acc_pnt, r_aw_pnt, r_cmt_pnt;
  logic [OccW-1:0]    r_occ, r_aw_cnt;
  logic [CntW-1:0]    r_outstanding;
  logic [NrVInsn-1:0] r_done;
  logic               r_exc_vld;
  logic [IdW-1:0]     r_exc_id;

  logic w_acc, w_aw_hs, w_aw_close, w_b_hs, w_retire, w_head_err;

  assign insn_ready_o = (r_occ != OccW'(QueueDepth));
  assign aw_ready_o   = (r_aw_cnt != '0) && (r_outstanding < CntW'(MaxOutstanding));
  assign b_ready_o    = (r_occ != '0) && (r_bcnt[r_cmt_pnt] != '0);

  assign w_acc      = insn_valid_i && insn_ready_o;
  assign w_aw_hs    = aw_valid_i && aw_ready_o;
  assign w_aw_close = w_aw_hs && aw_last_i;
  assign w_b_hs     = b_valid_i && b_ready_o;
  assign w_head_err = r_err[r_cmt_pnt] || (b_resp_i != 2'b00);

  // A closed head can never receive an AW in the same cycle (the AW entry is
  // the oldest unclosed one), so the last B beat of a closed head retires it.
  // An unclosed head whose count hits zero simply waits for more bursts.
  assign w_retire = w_b_hs && (r_bcnt[r_cmt_pnt] == CntW'(1)) && r_closed[r_cmt_pnt];

  // Entry storage. An accepted slot is always free, so it never collides
  // with the AW or B target; AW and B may target the same entry and net out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < QueueDepth; i++) begin
        r_id[i]     <= '0;
        r_bcnt[i]   <= '0;
        r_closed[i] <= 1'b0;
        r_err[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < QueueDepth; i++) begin
        if (w_acc && (r_acc_pnt == PtrW'(i))) begin
          r_id[i]     <= insn_id_i;
          r_bcnt[i]   <= '0;
          r_closed[i] <= 1'b0;
          r_err[i]    <= 1'b0;
        end else begin
          r_bcnt[i] <= r_bcnt[i]
                       + CntW'(w_aw_hs && (r_aw_pnt == PtrW'(i)))
                       - CntW'(w_b_hs && (r_cmt_pnt == PtrW'(i)));
          if (w_aw_close && (r_aw_pnt == PtrW'(i)))
            r_closed[i] <= 1'b1;
          if (w_b_hs && (r_cmt_pnt == PtrW'(i)) && (b_resp_i != 2'b00))
            r_err[i] <= 1'b1;
        end
      end
    end
  end

  // Pointers, occupancy and outstanding counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc_pnt     <= '0;
      r_aw_pnt      <= '0;
      r_cmt_pnt     <= '0;
      r_occ         <= '0;
      r_aw_cnt      <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_acc)      r_acc_pnt <= r_acc_pnt + PtrW'(1);
      if (w_aw_close) r_aw_pnt  <= r_aw_pnt + PtrW'(1);
      if (w_retire)   r_cmt_pnt <= r_cmt_pnt + PtrW'(1);
      r_occ         <= r_occ + OccW'(w_acc) - OccW'(w_retire);
      r_aw_cnt      <= r_aw_cnt + OccW'(w_acc) - OccW'(w_aw_close);
      r_outstanding <= r_outstanding + CntW'(w_aw_hs) - CntW'(w_b_hs);
    end
  end

  // Registered retire and exception pulses; exception id holds between pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_done    <= '0;
      r_exc_vld <= 1'b0;
      r_exc_id  <= '0;
    end else begin
      r_done    <= w_retire ? (NrVInsn'(1) << r_id[r_cmt_pnt]) : '0;
      r_exc_vld <= w_retire && w_head_err;
      if (w_retire && w_head_err)
        r_exc_id <= r_id[r_cmt_pnt];
    end
  end

  assign vinsn_done_o      = r_done;
  assign exception_valid_o = r_exc_vld;
  assign exception_id_o    = r_exc_id;
  assign store_pending_o   = (r_occ != '0);
  assign outstanding_o     = r_outstanding;

endmodule

// File: tb/tb_vstu_commit_ctrl.sv
// Self-checking bench for vstu_commit_ctrl: directed scenarios with literal
// expectations plus a randomized run, all checked every cycle against a
// queue-based model of in-flight store instructions.
module tb_vstu_commit_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iv = 1'b0;
  logic [2:0] iid = '0;
  logic       awv = 1'b0, awl = 1'b0, bv = 1'b0;
  logic [1:0] bresp = '0;
  logic       insn_ready, aw_ready, b_ready, exc_vld, pending;
  logic [7:0] done;
  logic [2:0] exc_id;
  logic [4:0] outst;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vstu_commit_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .insn_valid_i(iv), .insn_id_i(iid), .insn_ready_o(insn_ready),
    .aw_ready_o(aw_ready), .aw_valid_i(awv), .aw_last_i(awl),
    .b_valid_i(bv), .b_resp_i(bresp), .b_ready_o(b_ready),
    .vinsn_done_o(done), .exception_valid_o(exc_vld), .exception_id_o(exc_id),
    .store_pending_o(pending), .outstanding_o(outst)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int id;
    int iss;   // bursts issued
    int ack;   // B beats received
    bit closed;
    bit err;
  } ent_t;

  ent_t mq[$];
  logic [7:0] m_done = '0;
  bit m_exc = 0;
  int m_exc_id = 0;

  function automatic int m_out();
    int s = 0;
    foreach (mq[i]) s += mq[i].iss - mq[i].ack;
    return s;
  endfunction

  function automatic int m_first_open();
    foreach (mq[i]) if (!mq[i].closed) return i;
    return -1;
  endfunction

  function automatic bit m_aw_ready();
    return (m_first_open() >= 0) && (m_out() < 16);
  endfunction

  function automatic bit m_b_ready();
    return (mq.size() != 0) && (mq[0].iss != mq[0].ack);
  endfunction

  ent_t e;
  bit   r_ir, r_ar, r_br, r_hdc;
  int   k;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_done = '0;
      m_exc = 0;
      m_exc_id = 0;
    end else begin
      r_ir = (mq.size() != 4);
      r_ar = m_aw_ready();
      r_br = m_b_ready();
      r_hdc = (mq.size() != 0) && mq[0].closed;
      m_done = '0;
      m_exc = 0;
      if (bv && r_br) begin
        e = mq[0];
        e.ack++;
        if (bresp != 2'b00) e.err = 1;
        mq[0] = e;
      end
      if (awv && r_ar) begin
        k = m_first_open();
        e = mq[k];
        e.iss++;
        if (awl) e.closed = 1;
        mq[k] = e;
      end
      // Retire only a head that was already closed before this cycle and is now fully acknowledged
      if (bv && r_br && r_hdc && (mq[0].iss == mq[0].ack)) begin
        m_done = 8'(1) << mq[0].id;
        m_exc = mq[0].err;
        if (mq[0].err) m_exc_id = mq[0].id;
        void'(mq.pop_front());
      end
      if (iv && r_ir) begin
        e.id = int'(iid); e.iss = 0; e.ack = 0; e.closed = 0; e.err = 0;
        mq.push_back(e);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("insn_ready", int'(insn_ready), int'(mq.size() != 4));
    chk("aw_ready", int'(aw_ready), int'(m_aw_ready()));
    chk("b_ready", int'(b_ready), int'(m_b_ready()));
    chk("store_pending", int'(pending), int'(mq.size() != 0));
    chk("outstanding", int'(outst), m_out());
    chk("vinsn_done", int'(done), int'(m_done));
    chk("exception_valid", int'(exc_vld), int'(m_exc));
    if (m_exc) chk("exception_id", int'(exc_id), m_exc_id);
  end

  // ---------------- stimulus ----------------
  // Drive one cycle of inputs; returns at negedge+1 with the edge's results visible.
  task automatic cyc(input logic i_v, input logic [2:0] i_id, input logic a_v,
                     input logic a_l, input logic b_v, input logic [1:0] b_r);
    iv = i_v; iid = i_id; awv = a_v; awl = a_l; bv = b_v; bresp = b_r;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 3'd0, 0, 0, 0, 2'b00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    iv = 0; awv = 0; awl = 0; bv = 0; bresp = 2'b00;
    #2;
    chk("rst_insn_ready", int'(insn_ready), 1);
    chk("rst_aw_ready", int'(aw_ready), 0);
    chk("rst_b_ready", int'(b_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_exc_valid", int'(exc_vld), 0);
    chk("rst_exc_id", int'(exc_id), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_outstanding", int'(outst), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    idle();

    // 1: single instruction, three bursts
    cyc(1, 3'd3, 0, 0, 0, 2'b00);
    cyc(0, 3'd0, 1, 0, 0, 2'b00);
    cyc(0, 3'd0, 1, 0, 0, 2'b00);
    cyc(0, 3'd0, 1, 1, 0, 2'b00);
    chk("t1_outstanding", int'(outst), 3);
    cyc(0, 3'd0, 0, 0, 1, 2'b00);
    cyc(0, 3'd0, 0, 0, 1, 2'b00);
    chk("t1_no_early_done", int'(done), 0);
    chk("t1_pending_before", int'(pending), 1);
    cyc(0, 3'd0, 0, 0, 1, 2'b00);
    chk("t1_done", int'(done), 8'h08);
    chk("t1_pending_after", int'(pending), 0);
    idle();
    chk("t1_done_pulse", int'(done), 0);

    // 2: two instructions back-to-back
    cyc(1, 3'd1, 0, 0, 0, 2'b00);
    cyc(1, 3'd2, 1, 0, 0, 2'b00);
    cyc(0, 3'd0, 1, 1, 0, 2'b00);
    cyc(0, 3'd0, 1, 1, 0, 2'b00);
    cyc(0, 3'd0, 0, 0, 1, 2'b00);
    chk("t2_no_done", int'(done), 0);
    cyc(0, 3'd0, 0, 0, 1, 2'b00);
    chk("t2_done1", int'(done), 8'h02);
    cyc(0, 3'd0, 0, 0, 1, 2'b00);
    chk("t2_done2", int'(done), 8'h04);
    idle();

    // 3: outstanding limit
    cyc(1, 3'd7, 0, 0, 0, 2'b00);
    for (int i = 0; i < 16; i++) cyc(0, 3'd0, 1, 0, 0, 2'b00);
    chk("t3_aw_ready_full", int'(aw_ready), 0);
    chk("t3_outstanding16", int'(outst), 16);
    cyc(0, 3'd0, 1, 0, 0, 2'b00);
    chk("t3_ignored_aw", int'(outst), 16);
    cyc(0, 3'd0, 0, 0, 1, 2'b00);
    chk("t3_aw_ready_again", int'(aw_ready), 1);
    cyc(0, 3'd0, 1, 1, 0, 2'b00);
    for (int i = 0; i < 16; i++) cyc(0, 3'd0, 0, 0, 1, 2'b00);
    chk("t3_done", int'(done), 8'h80);

    // 4: queue full
    for (int i = 0; i < 4; i++) cyc(1, 3'(i), 0, 0, 0, 2'b00);
    chk("t4_not_ready", int'(insn_ready), 0);
    cyc(1, 3'd6, 1, 1, 0, 2'b00);
    for (int i = 0; i < 3; i++) cyc(0, 3'd0, 1, 1, 0, 2'b00);
    cyc(0, 3'd0, 0, 0, 1, 2'b00);
    chk("t4_done0", int'(done), 8'h01);
    chk("t4_ready_again", int'(insn_ready), 1);
    for (int i = 0; i < 3; i++) cyc(0, 3'd0, 0, 0, 1, 2'b00);
    chk("t4_drained", int'(pending), 0);

    // 5: error response
    cyc(1, 3'd5, 0, 0, 0, 2'b00);
    cyc(0, 3'd0, 1, 0, 0, 2'b00);
    cyc(0, 3'd0, 1, 1, 0, 2'b00);
    cyc(0, 3'd0, 0, 0, 1, 2'b00);
    cyc(0, 3'd0, 0, 0, 1, 2'b10);
    chk("t5_done", int'(done), 8'h20);
    chk("t5_exc_valid", int'(exc_vld), 1);
    chk("t5_exc_id", int'(exc_id), 5);
    idle();
    chk("t5_exc_pulse", int'(exc_vld), 0);

    // 6: AW last and draining B on the head in the same cycle
    cyc(1, 3'd0, 0, 0, 0, 2'b00);
    cyc(0, 3'd0, 1, 0, 0, 2'b00);
    cyc(0, 3'd0, 1, 1, 1, 2'b00);
    chk("t6_no_retire", int'(done), 0);
    chk("t6_outstanding", int'(outst), 1);
    chk("t6_b_ready", int'(b_ready), 1);
    cyc(0, 3'd0, 0, 0, 1, 2'b00);
    chk("t6_done", int'(done), 8'h01);
    chk("t6_exc_clean", int'(exc_vld), 0);

    // Randomized traffic, alternating B-starved and B-heavy phases
    for (int n = 0; n < 4000; n++) begin
      automatic int bpct = ((n / 250) % 2 == 0) ? 20 : 75;
      cyc(($urandom_range(0, 99) < 35), 3'($urandom_range(0, 7)),
          ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 30),
          ($urandom_range(0, 99) < bpct),
          ($urandom_range(0, 99) < 85) ? 2'b00 : 2'($urandom_range(1, 3)));
    end

    // Reset mid-burst discards tracking
    idle();
    cyc(1, 3'd4, 0, 0, 0, 2'b00);
    cyc(0, 3'd0, 1, 0, 0, 2'b00);
    cyc(0, 3'd0, 1, 1, 1, 2'b00);
    do_reset();
    cyc(0, 3'd0, 0, 0, 1, 2'b00);
    chk("rst_mid_no_done", int'(done), 0);
    chk("rst_mid_pending", int'(pending), 0);
    chk("rst_mid_outstanding", int'(outst), 0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vstu_commit_ctrl.md
Name: vstu_commit_ctrl

Overview:
- Commit/scheduling controller for the vector store unit's AXI write path.
- Tracks, per in-flight store instruction, the AW bursts issued and the B responses returned. Retires an instruction (vinsn_done pulse) only after its last burst is acknowledged.
- Throttles AW issue so total outstanding bursts never exceed a configured limit.
- Sits between the main sequencer (instruction accept), the address generator (AW issue) and the AXI B channel.

Parameters:
- NrVInsn, 8, number of vector instruction IDs; ID width IdW = $clog2(NrVInsn).
- QueueDepth, 4, in-flight store instructions tracked (power of two).
- MaxOutstanding, 16, max AW bursts awaiting B across all instructions; counter width CntW = $clog2(MaxOutstanding+1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- insn_valid_i  in  1  new store instruction offered
- insn_id_i  in  IdW  its instruction ID
- insn_ready_o  out  1  queue not full
- aw_ready_o  out  1  permission for the address generator to issue one AW burst
- aw_valid_i  in  1  AW burst issued this cycle; counted only when aw_ready_o=1
- aw_last_i  in  1  qualifies aw_valid_i: this is the instruction's final burst
- b_valid_i  in  1  AXI B beat valid
- b_resp_i  in  2  AXI B response
- b_ready_o  out  1  B beat accepted
- vinsn_done_o  out  NrVInsn  one-hot retire pulse, registered
- exception_valid_o  out  1  retired instruction saw a non-OKAY response, registered pulse
- exception_id_o  out  IdW  ID of that instruction
- store_pending_o  out  1  at least one instruction in queue
- outstanding_o  out  CntW  total bursts awaiting B

Behaviour:
- Reset is asynchronous and active-low. On reset:
  - all pointers, counters and entries are cleared;
  - insn_ready_o=1, aw_ready_o=0, b_ready_o=0, vinsn_done_o=0, exception_valid_o=0, exception_id_o=0, store_pending_o=0, outstanding_o=0.
  - Reset mid-operation discards all tracking; no done pulses are emitted.
- Entry fields: id, bcnt (CntW bits, bursts issued minus B received), closed (last burst issued), err (sticky).
- Pointers wrap modulo QueueDepth:
  - acc_pnt: allocate;
  - aw_pnt: entry receiving bursts;
  - cmt_pnt: head awaiting B.
- Occupancy counters: occ (0..QueueDepth), aw_cnt (entries not yet closed).
- Accept: insn_ready_o = (occ_q != QueueDepth), from registers only. On insn_valid_i && insn_ready_o:
  - write entry[acc_pnt] = {id, bcnt=0, closed=0, err=0};
  - acc_pnt++, occ++, aw_cnt++.
  - Accept on the same cycle a retire frees a slot is not allowed; ready is registered.
- AW: aw_ready_o = (aw_cnt_q != 0) && (outstanding_q < MaxOutstanding), from registers only. On aw_valid_i && aw_ready_o:
  - entry[aw_pnt].bcnt++, outstanding++.
  - If aw_last_i: set closed, aw_pnt++, aw_cnt--.
  - aw_valid_i while aw_ready_o=0 is ignored.
  - An instruction accepted in cycle N may issue from cycle N+1.
- B: b_ready_o = (occ_q != 0) && (entry[cmt_pnt].bcnt_q != 0). B beats arrive in AW order (single AXI ID). On handshake:
  - entry[cmt_pnt].bcnt--, outstanding--;
  - if b_resp_i != OKAY (2'b00), set err.
- Retire occurs when the B handshake makes head bcnt 0 and head closed=1. In that cycle:
  - cmt_pnt++, occ--;
  - next cycle: vinsn_done_o[id]=1 for exactly one cycle;
  - if err (including the current beat's response), exception_valid_o=1 and exception_id_o=id in the same cycle as done.
- Simultaneous AW and B on the same entry: bcnt net unchanged, outstanding net unchanged. If AW carries last and B drains to zero in the same cycle, no retire occurs: the pending burst keeps bcnt at 1.
- Head not closed and bcnt reaches 0: no retire; the entry waits for more bursts.
- Simultaneous accept, AW and B are all processed in one cycle.
- outstanding_o and store_pending_o (occ_q != 0) are registered.
- At most one retire per cycle.

Test Plan:
1. Accept id 3; issue 3 bursts, last on the third; return 3 OKAY B beats -> vinsn_done_o=8'h08 one cycle after the 3rd B; store_pending_o falls in the same cycle; no earlier pulse.
2. Accept ids 1 and 2 back-to-back; id1 gets 2 bursts (last), id2 gets 1 burst; 3 B beats -> done[1] after the 2nd B, done[2] after the 3rd, on distinct cycles.
3. MaxOutstanding=16: issue 16 bursts with no B -> aw_ready_o=0, outstanding_o=16; one B beat -> aw_ready_o=1 next cycle.
4. Accept 4 instructions -> insn_ready_o=0; an insn_valid_i presented while not ready is not accepted; retire one -> insn_ready_o=1 the following cycle.
5. Id 5 with 2 bursts, second B has b_resp=2'b10 -> done[5] and exception_valid_o=1, exception_id_o=5 in the same cycle.
6. Head id 0 with 1 burst outstanding: AW last and B handshake in the same cycle -> no retire, bcnt stays 1; the next B retires id 0. Separately, assert rst_ni mid-burst -> all outputs return to reset values, no done pulse.
